// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer slice.
// The optional false-start feature is selected in the top module with the
// macro RANDOM_DELAY_FALSE_START_EN.
package reaction_pkg;

  // Width of the measured reaction time in ms
  localparam int RESULT_W = 14;

  // Width of the pseudo-random delay extension
  localparam int RAND_W = 10;

  // Trial sequencing
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Counter width for a modulus, never less than one bit
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every CLKS_PER_MS cycles.
// A synchronous clear restarts the count so that the first tick lands
// CLKS_PER_MS cycles after the clear is released.
module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = clog2_min1(CLKS_PER_MS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divider, wrapped at LAST and restarted by clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tick is suppressed while cleared so an idle timer never advances
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/random_delay_timer.sv
// Reaction-time trial controller.
// A start in IDLE loads a random pre-stimulus delay (MIN_DELAY_MS + rand_num
// ms). When it expires the stimulus LED is lit and the time to the first
// button press edge is measured in ms, saturating at MAX_REACT_MS (timeout).
// The result is published with a one-cycle result_valid pulse.
// Optional feature: define RANDOM_DELAY_FALSE_START_EN to report a press
// during the random delay as a false start; otherwise such presses are ignored.
module random_delay_timer
  import reaction_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RAND_W-1:0]   rand_num,
  input  logic                btn,
  output logic                stimulus,
  output logic                busy,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  output logic                false_start,
  output logic                timeout
);

  localparam int CLKS_PER_MS = (CLK_FREQ_HZ / 1000 > 1) ? (CLK_FREQ_HZ / 1000) : 1;
  // Delay register must hold MIN_DELAY_MS + (2**RAND_W - 1)
  localparam int DELAY_W = clog2_min1(MIN_DELAY_MS + (1 << RAND_W));
  localparam logic [RESULT_W-1:0] MAX_CNT = RESULT_W'(MAX_REACT_MS);

  state_t              state;
  state_t              state_nxt;
  logic                btn_q;
  logic [DELAY_W-1:0]  delay;
  logic [RESULT_W-1:0] cnt;
  logic [RESULT_W-1:0] cnt_inc;
  logic                tick;
  logic                tick_clr;
  logic                press;
  logic                delay_done;
  logic                react_to;
  logic                wait_press;

  // Prescaler is held cleared in IDLE, so it restarts on the accepted start
  assign tick_clr = (state == ST_IDLE);

  ms_tick_gen #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  // A press is a rising edge of the already-synchronised button level
  assign press = btn && !btn_q;

  // Delay expires on the tick that takes it to zero
  assign delay_done = tick && (delay <= DELAY_W'(1));

`ifdef RANDOM_DELAY_FALSE_START_EN
  assign wait_press = press;
`else
  assign wait_press = 1'b0;
`endif

  // Reaction count including this cycle's tick, so a press on a tick edge
  // reports the count that tick produces
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_inc unassigned (no latch).
    cnt_inc = cnt;
    if (tick && (cnt < MAX_CNT)) begin
      cnt_inc = cnt + 1'b1;
    end
  end

  assign react_to = tick && (cnt_inc >= MAX_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_press)      state_nxt = ST_REPORT;
        else if (delay_done) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (press || react_to) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    stimulus     = (state == ST_ARMED);
    busy         = (state != ST_IDLE);
    result_valid = (state == ST_REPORT);
  end

  // Button history, delay and reaction counters, result and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q       <= 1'b0;
      delay       <= '0;
      cnt         <= '0;
      result_ms   <= '0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      btn_q <= btn;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            delay       <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(rand_num);
            cnt         <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_press) begin
            false_start <= 1'b1;
            result_ms   <= '0;
          end else if (tick) begin
            if (delay != '0) delay <= delay - 1'b1;
            if (delay_done)  cnt   <= '0;
          end
        end
        ST_ARMED: begin
          cnt <= cnt_inc;
          // Press wins over a simultaneous timeout tick
          if (press) begin
            result_ms <= cnt_inc;
          end else if (react_to) begin
            timeout   <= 1'b1;
            result_ms <= MAX_CNT;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// Scoreboard bench for random_delay_timer with a 1-cycle ms tick
// (CLK_FREQ_HZ=1000), MIN_DELAY_MS=2 and MAX_REACT_MS=20.
module tb_random_delay_timer;
  import reaction_pkg::*;

  localparam int CLK_FREQ_HZ  = 1000;
  localparam int MIN_DELAY_MS = 2;
  localparam int MAX_REACT_MS = 20;
  localparam int BOUND        = 200;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [RAND_W-1:0]   rand_num;
  logic                btn;
  logic                stimulus;
  logic                busy;
  logic [RESULT_W-1:0] result_ms;
  logic                result_valid;
  logic                false_start;
  logic                timeout;

  typedef struct packed {
    logic [RESULT_W-1:0] ms;
    logic                to;
    logic                fs;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_valid    = 0;
  int   stim_count = 0;

  always #5 clk = ~clk;

  random_delay_timer #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .MAX_REACT_MS (MAX_REACT_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rand_num     (rand_num),
    .btn          (btn),
    .stimulus     (stimulus),
    .busy         (busy),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_result(input int ms, input bit to, input bit fs);
    exp_t e;
    e.ms = RESULT_W'(ms);
    e.to = to;
    e.fs = fs;
    sb.push_back(e);
  endtask

  // Output monitor: pops the scoreboard on each result pulse
  always @(negedge clk) begin
    exp_t e;
    if (stimulus) stim_count++;
    if (result_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("spurious_valid", result_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("result_ms", result_ms, e.ms);
        check("timeout_flag", timeout, e.to);
        check("false_start_flag", false_start, e.fs);
      end
    end
  end

  task automatic do_start(input int r);
    @(negedge clk);
    start    = 1'b1;
    rand_num = r[RAND_W-1:0];
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_stim(output int n);
    n = 0;
    while (!stimulus && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Press so the edge coincides with the k-th tick after stimulus rises
  task automatic press_at(input int k);
    repeat (k - 1) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int v0;
    int s0;

    rst = 1'b1; start = 1'b0; btn = 1'b0; rand_num = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_stimulus", stimulus, 1'b0);
    check("rst_result_ms", result_ms, 0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_flags", {false_start, timeout}, 2'b00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst", busy, 1'b0);

    // Normal trial: delay 2+3, reaction of 7 ms
    v0 = n_valid;
    do_start(3);
    check("busy_after_start", busy, 1'b1);
    check("no_stim_in_wait", stimulus, 1'b0);
    wait_stim(n);
    check("stim_delay_5", n, 5);
    expect_result(7, 1'b0, 1'b0);
    press_at(7);
    wait_idle(n);
    check("idle_after_report", busy, 1'b0);
    check("pulses_trial1", n_valid - v0, 1);
    check("result_hold", result_ms, 7);

    // Timeout trial: no press for MAX_REACT_MS ticks
    v0 = n_valid;
    do_start(0);
    s0 = stim_count;
    wait_stim(n);
    check("stim_delay_2", n, 2);
    expect_result(MAX_REACT_MS, 1'b1, 1'b0);
    wait_idle(n);
    check("idle_after_timeout", busy, 1'b0);
    check("pulses_timeout", n_valid - v0, 1);
    check("stim_cycles_timeout", stim_count - s0, MAX_REACT_MS);
    check("timeout_sticky", timeout, 1'b1);
    check("timeout_result_hold", result_ms, MAX_REACT_MS);

    // Press on the same tick that would time out: press wins
    v0 = n_valid;
    do_start(1);
    check("timeout_cleared_on_start", timeout, 1'b0);
    wait_stim(n);
    check("stim_delay_3", n, 3);
    expect_result(MAX_REACT_MS, 1'b0, 1'b0);
    press_at(MAX_REACT_MS);
    wait_idle(n);
    check("pulses_tie", n_valid - v0, 1);
    check("tie_no_timeout", timeout, 1'b0);

    // Press during the random delay
    v0 = n_valid;
    s0 = stim_count;
    do_start(10);
`ifdef RANDOM_DELAY_FALSE_START_EN
    expect_result(0, 1'b0, 1'b1);
`endif
    repeat (3) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
`ifdef RANDOM_DELAY_FALSE_START_EN
    wait_idle(n);
    check("fs_idle", busy, 1'b0);
    check("fs_flag", false_start, 1'b1);
    check("fs_result", result_ms, 0);
    check("fs_no_stim", stim_count - s0, 0);
    check("pulses_fs", n_valid - v0, 1);
`else
    check("wait_press_ignored", busy, 1'b1);
    wait_stim(n);
    check("stim_after_ignored_press", n, 8);
    expect_result(4, 1'b0, 1'b0);
    press_at(4);
    wait_idle(n);
    check("no_false_start", false_start, 1'b0);
    check("pulses_ignored_press", n_valid - v0, 1);
`endif

    // Start pulses mid-trial are ignored; a held button is one edge only
    v0 = n_valid;
    do_start(5);
    @(negedge clk);
    start = 1'b1; rand_num = 10'd500;
    @(negedge clk);
    start = 1'b0;
    wait_stim(n);
    check("stim_delay_ignores_start", n, 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_result(4, 1'b0, 1'b0);
    @(negedge clk);
    btn = 1'b1;
    repeat (40) @(negedge clk);
    check("held_btn_one_pulse", n_valid - v0, 1);
    check("held_btn_idle", busy, 1'b0);

    v0 = n_valid;
    do_start(0);
    wait_stim(n);
    check("stim_delay_held_btn", n, 2);
    expect_result(MAX_REACT_MS, 1'b1, 1'b0);
    wait_idle(n);
    check("held_btn_times_out", timeout, 1'b1);
    check("pulses_held_btn", n_valid - v0, 1);
    btn = 1'b0;

    // Reset during ARMED aborts the trial
    v0 = n_valid;
    do_start(0);
    wait_stim(n);
    check("stim_delay_abort", n, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_stimulus", stimulus, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", result_valid, 1'b0);
    check("abort_result", result_ms, 0);
    check("abort_flags", {false_start, timeout}, 2'b00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_reset_ignored", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_pulse", n_valid - v0, 0);
    check("abort_stays_idle", busy, 1'b0);
    check("abort_no_flags", {false_start, timeout}, 2'b00);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/random_delay_timer.md
RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency used to derive the 1 ms tick.
REQ-002 SHALL have parameter MIN_DELAY_MS, default 1000, fixed part of the pre-stimulus delay in ms.
REQ-003 SHALL have parameter MAX_REACT_MS, default 9999, reaction timeout in ms (at most 16383).
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit, single-cycle request to begin a trial.
REQ-007 SHALL have port rand_num, input, 10 bits, pseudo-random value from the LFSR stage, sampled on start.
REQ-008 SHALL have port btn, input, 1 bit, synchronized active-high user button level.
REQ-009 SHALL have port stimulus, output, 1 bit, drives the LED; high while waiting for the user's response.
REQ-010 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-011 SHALL have port result_ms, output, 14 bits, measured reaction time in ms.
REQ-012 SHALL have port result_valid, output, 1 bit, one-cycle pulse when result_ms is updated.
REQ-013 SHALL have port false_start, output, 1 bit, sticky flag until the next accepted start.
REQ-014 SHALL have port timeout, output, 1 bit, sticky flag until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, WAIT, ARMED and REPORT.
REQ-016 SHALL, on start in IDLE, latch rand_num, load delay = MIN_DELAY_MS + rand_num (range MIN..MIN+1023), clear the prescaler, clear both flags, and enter WAIT.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL generate a 1 ms tick every CLKS_PER_MS = CLK_FREQ_HZ/1000 cycles, counted from the cycle after start is accepted.
REQ-019 SHALL, in WAIT, decrement delay on each tick and enter ARMED on the tick where delay reaches 0.
REQ-020 SHALL assert stimulus from the first ARMED cycle until ARMED is left.
REQ-021 SHALL, in ARMED, clear its ms counter on entry and increment it on each tick, saturating at MAX_REACT_MS.
REQ-022 SHALL detect a press as a btn rising edge, i.e. btn high and the btn value registered on the previous cycle low.
REQ-023 SHALL, on a press edge in ARMED, load result_ms with the current count, enter REPORT, and drop stimulus on the next cycle.
REQ-024 SHALL, when the count reaches MAX_REACT_MS in ARMED, set timeout, load result_ms = MAX_REACT_MS, and enter REPORT.
REQ-025 SHALL give the press priority when a press edge and the timeout tick occur in the same cycle: timeout stays 0 and result_ms takes the count.
REQ-026 SHALL, in REPORT, pulse result_valid for exactly one cycle and return to IDLE on the next cycle.
REQ-027 SHALL hold result_ms and the flags until the next accepted start.
REQ-028 SHALL ignore btn in IDLE and REPORT.
REQ-029 SHALL cover the WAIT-state press behaviour through REQ-033 and REQ-034.

Reset
REQ-030 SHALL, while rst is high, force state IDLE and stimulus=0, busy=0, result_ms=0, result_valid=0, false_start=0, timeout=0, and clear all counters and the registered btn.
REQ-031 SHALL treat reset asserted mid-trial as an abort: no result_valid pulse and no flag is produced.
REQ-032 SHALL leave IDLE only on start after rst is deasserted.

Configuration
REQ-033 SHALL, with macro RANDOM_DELAY_FALSE_START_EN defined, treat a press edge in WAIT as a false start: set false_start, load result_ms=0, enter REPORT (one result_valid pulse), and never assert stimulus.
REQ-034 SHALL, without RANDOM_DELAY_FALSE_START_EN, ignore presses in WAIT; false_start then stays at 0.

Structure
REQ-035 SHALL place the state enum, the 14-bit result width constant and the 10-bit rand width constant in shared package reaction_pkg.
REQ-036 SHALL implement the prescaler as sub-module ms_tick_gen, with a synchronous clear input and a one-cycle tick output.

Verification (CLK_FREQ_HZ=1000 so CLKS_PER_MS=1, MIN_DELAY_MS=2, MAX_REACT_MS=20)
REQ-037 SHALL check: start with rand_num=3 -> busy=1; stimulus rises 5 ticks after start; press edge 7 ticks later -> result_valid pulse with result_ms=7, then IDLE.
REQ-038 SHALL check: no press after stimulus rises -> after 20 ticks timeout=1, result_ms=20, one result_valid pulse.
REQ-039 SHALL check: press edge in the same cycle as the 20th tick -> timeout=0, result_ms=20.
REQ-040 SHALL check, with RANDOM_DELAY_FALSE_START_EN: press during WAIT -> false_start=1, result_ms=0, stimulus never 1; without the macro, the same press is ignored and the trial completes.
REQ-041 SHALL check: start pulses during WAIT and ARMED have no effect, and btn held high continuously gives only one press edge.
REQ-042 SHALL check: rst asserted in ARMED -> all outputs 0 immediately, and no result_valid pulse after release.
